uart_result_writer: RTL and testbench

UART_RESULT_WRITER -- requirements
Module: uart_result_writer

---
 rtl/uart_result_writer.sv | 127 ++++++++++++
 tb/tb_uart_result_writer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_result_writer.sv
// Serialises an N_BYTES payload over an 8N1 UART line, byte 0 first, with
// the bytes sent back-to-back and a one-cycle done pulse at the end of the burst.
module uart_result_writer #(
  parameter int c_clkfreq  = 100_000_000,
  parameter int c_baudrate = 115_200,
  parameter int N_BYTES    = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [8*N_BYTES-1:0]   data_i,
  output logic                   tx_o,
  output logic                   busy_o,
  output logic                   tx_done_tick_o
);

  localparam int BIT_TICKS = c_clkfreq / c_baudrate;
  localparam int TICK_W    = $clog2(BIT_TICKS);
  localparam int BYTE_W    = $clog2(N_BYTES + 1);
  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(BIT_TICKS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(N_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state, state_next;
  logic [TICK_W-1:0]      tick_cnt, tick_next;
  logic [2:0]             bit_cnt, bit_next;
  logic [BYTE_W-1:0]      byte_cnt, byte_next;
  logic [8*N_BYTES-1:0]   shreg, shreg_next;
  logic                   tx_next, busy_next, done_next;
  logic                   period_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      tick_cnt       <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      tx_o           <= 1'b1;
      busy_o         <= 1'b0;
      tx_done_tick_o <= 1'b0;
    end else begin
      state          <= state_next;
      tick_cnt       <= tick_next;
      bit_cnt        <= bit_next;
      byte_cnt       <= byte_next;
      tx_o           <= tx_next;
      busy_o         <= busy_next;
      tx_done_tick_o <= done_next;
    end
  end

  // Payload buffer carries no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    shreg <= shreg_next;
  end

  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    bit_next   = bit_cnt;
    byte_next  = byte_cnt;
    shreg_next = shreg;
    tx_next    = tx_o;
    busy_next  = busy_o;
    done_next  = 1'b0;
    period_end = (tick_cnt == TICK_MAX);

    case (state)
      IDLE: begin
        // A start coinciding with the done pulse is dropped deliberately.
        if (start_i && !tx_done_tick_o) begin
          state_next = START;
          shreg_next = data_i;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          tick_next  = '0;
          bit_next   = '0;
          byte_next  = '0;
        end
      end
      START: begin
        if (period_end) begin
          tick_next  = '0;
          state_next = DATA;
          tx_next    = shreg[0];
        end else begin
          tick_next = tick_cnt + 1'b1;
        end
      end
      DATA: begin
        if (period_end) begin
          tick_next  = '0;
          shreg_next = shreg >> 1;
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next = shreg[1];
          end
        end else begin
          tick_next = tick_cnt + 1'b1;
        end
      end
      STOP: begin
        if (period_end) begin
          tick_next = '0;
          if (byte_cnt == LAST_BYTE) begin
            state_next = IDLE;
            byte_next  = '0;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end else begin
            byte_next  = byte_cnt + 1'b1;
            state_next = START;
            tx_next    = 1'b0;
          end
        end else begin
          tick_next = tick_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_result_writer.sv
// Directed bench: a 2-byte, 4-clocks-per-bit instance for protocol corner cases
// and a default-parameter instance running a full 10-byte burst alongside.
module tb_uart_result_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance: BIT_TICKS = 4, N_BYTES = 2
  logic        rst_s = 1'b1, start_s = 1'b0;
  logic [15:0] data_s = '0;
  logic        tx_s, busy_s, done_s;

  uart_result_writer #(.c_clkfreq(400), .c_baudrate(100), .N_BYTES(2)) dut_s (
    .clk(clk), .rst(rst_s), .start_i(start_s), .data_i(data_s),
    .tx_o(tx_s), .busy_o(busy_s), .tx_done_tick_o(done_s)
  );

  // Default instance: BIT_TICKS = 868, N_BYTES = 10
  logic        rst_b = 1'b1, start_b = 1'b0;
  logic [79:0] data_b = '0;
  logic        tx_b, busy_b, done_b;

  uart_result_writer dut_b (
    .clk(clk), .rst(rst_b), .start_i(start_b), .data_i(data_b),
    .tx_o(tx_b), .busy_o(busy_b), .tx_done_tick_o(done_b)
  );

  int checks = 0;
  int errors = 0;

  // Small-instance UART decoder and event recorder
  localparam int BTS = 4;
  logic [7:0] q_s[$];
  int   rs_cnt = 0, fe_s = 0, se_s = 0, dn_s = 0, done_cyc_s = 0, start_cyc_s = 0;
  logic rs_act = 1'b0, busy_prev_s = 1'b0;
  logic [7:0] rs_sh = '0;

  always @(negedge clk) begin
    if (rst_s) begin
      rs_act      = 1'b0;
      busy_prev_s = 1'b0;
    end else begin
      if (busy_s && !busy_prev_s) start_cyc_s = cyc;
      busy_prev_s = busy_s;
      if (done_s) begin
        dn_s++;
        done_cyc_s = cyc;
      end
      if (!rs_act && !tx_s) begin
        rs_act = 1'b1;
        rs_cnt = 0;
      end
      if (rs_act) begin
        if (rs_cnt < BTS && tx_s) se_s++;
        if (rs_cnt % BTS == BTS / 2) begin
          if (rs_cnt / BTS >= 1 && rs_cnt / BTS <= 8) rs_sh = {tx_s, rs_sh[7:1]};
          if (rs_cnt / BTS == 9) begin
            if (!tx_s) fe_s++;
            q_s.push_back(rs_sh);
            rs_act = 1'b0;
          end
        end
        rs_cnt++;
      end
    end
  end

  // Default-instance UART decoder and busy-length counter
  localparam int BTB = 868;
  logic [7:0] q_b[$];
  int   rb_cnt = 0, fe_b = 0, dn_b = 0, bc_b = 0;
  logic rb_act = 1'b0;
  logic [7:0] rb_sh = '0;

  always @(negedge clk) begin
    if (rst_b) begin
      rb_act = 1'b0;
    end else begin
      if (busy_b) bc_b++;
      if (done_b) dn_b++;
      if (!rb_act && !tx_b) begin
        rb_act = 1'b1;
        rb_cnt = 0;
      end
      if (rb_act) begin
        if (rb_cnt % BTB == BTB / 2) begin
          if (rb_cnt / BTB >= 1 && rb_cnt / BTB <= 8) rb_sh = {tx_b, rb_sh[7:1]};
          if (rb_cnt / BTB == 9) begin
            if (!tx_b) fe_b++;
            q_b.push_back(rb_sh);
            rb_act = 1'b0;
          end
        end
        rb_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Steps until the small instance shows its done pulse, bounded by maxc cycles.
  task automatic wait_done_s(input int maxc, input string tag);
    int n = 0;
    while (!done_s && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {31'b0, done_s}, 32'd1);
  endtask

  task automatic pulse_start_s(input logic [15:0] d);
    data_s  = d;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
  endtask

  int nq, d0, n;

  initial begin
    // Reset state
    repeat (3) step();
    chk("rst_tx_s",   {31'b0, tx_s},   32'd1);
    chk("rst_busy_s", {31'b0, busy_s}, 32'd0);
    chk("rst_done_s", {31'b0, done_s}, 32'd0);
    chk("rst_tx_b",   {31'b0, tx_b},   32'd1);
    rst_s = 1'b0;
    rst_b = 1'b0;
    step();

    // Start the long default-parameter burst; it runs in the background
    for (int k = 0; k < 10; k++) data_b[8*k +: 8] = 8'(k);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_start_tx",   {31'b0, tx_b},   32'd0);
    chk("b_start_busy", {31'b0, busy_b}, 32'd1);

    // Basic burst
    step();
    nq = q_s.size();
    d0 = dn_s;
    pulse_start_s(16'hA53C);
    chk("a_start_tx",   {31'b0, tx_s},   32'd0);
    chk("a_start_busy", {31'b0, busy_s}, 32'd1);
    wait_done_s(200, "a_done_seen");
    chk("a_done_tx",   {31'b0, tx_s},   32'd1);
    chk("a_done_busy", {31'b0, busy_s}, 32'd0);
    chk("a_latency",   32'(done_cyc_s - start_cyc_s), 32'd80);
    step();
    chk("a_done_width", {31'b0, done_s}, 32'd0);
    chk("a_nbytes", 32'(q_s.size() - nq), 32'd2);
    chk("a_byte0",  {24'b0, q_s[nq]},     32'h3C);
    chk("a_byte1",  {24'b0, q_s[nq+1]},   32'hA5);
    chk("a_ndone",  32'(dn_s - d0),       32'd1);
    chk("a_startbit_len", 32'(se_s), 32'd0);
    chk("a_stopbit",      32'(fe_s), 32'd0);

    // Data latched at acceptance; later input changes are ignored
    nq = q_s.size();
    data_s  = 16'hA53C;
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    data_s  = 16'hFFFF;
    wait_done_s(200, "b_done_seen");
    step();
    chk("b_nbytes", 32'(q_s.size() - nq), 32'd2);
    chk("b_byte0",  {24'b0, q_s[nq]},     32'h3C);
    chk("b_byte1",  {24'b0, q_s[nq+1]},   32'hA5);

    // Starts while busy and in the done cycle are ignored
    nq = q_s.size();
    d0 = dn_s;
    pulse_start_s(16'hA53C);
    repeat (30) step();
    start_s = 1'b1;
    step();
    start_s = 1'b0;
    wait_done_s(200, "c_done_seen");
    start_s = 1'b1;
    step();
    chk("c_ign_busy", {31'b0, busy_s}, 32'd0);
    chk("c_ign_tx",   {31'b0, tx_s},   32'd1);
    chk("c_nbytes",   32'(q_s.size() - nq), 32'd2);
    chk("c_ndone",    32'(dn_s - d0),       32'd1);
    step();
    start_s = 1'b0;
    chk("c_new_busy", {31'b0, busy_s}, 32'd1);
    chk("c_new_tx",   {31'b0, tx_s},   32'd0);
    wait_done_s(200, "c_done2_seen");
    step();
    chk("c_nbytes2", 32'(q_s.size() - nq), 32'd4);

    // Reset during bit 3 of byte 0 aborts the burst
    nq = q_s.size();
    d0 = dn_s;
    pulse_start_s(16'hA53C);
    repeat (17) step();
    rst_s = 1'b1;
    step();
    rst_s = 1'b0;
    chk("d_rst_tx",   {31'b0, tx_s},   32'd1);
    chk("d_rst_busy", {31'b0, busy_s}, 32'd0);
    repeat (100) step();
    chk("d_no_done",  32'(dn_s - d0),       32'd0);
    chk("d_no_bytes", 32'(q_s.size() - nq), 32'd0);
    pulse_start_s(16'hA53C);
    wait_done_s(200, "d_done_seen");
    step();
    chk("d_nbytes", 32'(q_s.size() - nq), 32'd2);
    chk("d_byte0",  {24'b0, q_s[nq]},     32'h3C);
    chk("d_byte1",  {24'b0, q_s[nq+1]},   32'hA5);
    chk("d_ndone",  32'(dn_s - d0),       32'd1);

    // Default-parameter burst completion
    n = 0;
    while (dn_b == 0 && n < 90000) begin
      step();
      n++;
    end
    chk("e_done_seen", 32'(dn_b), 32'd1);
    step();
    chk("e_nbytes", 32'(q_b.size()), 32'd10);
    for (int k = 0; k < 10; k++) chk($sformatf("e_byte%0d", k), {24'b0, q_b[k]}, 32'(k));
    chk("e_busy_len", 32'(bc_b), 32'd86800);
    chk("e_stopbit",  32'(fe_b), 32'd0);
    chk("e_ndone",    32'(dn_b), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
